// File: rtl/ip_sel_ctrl.sv
// rtl/ip_sel_ctrl.sv - IP select pad synchronizer, debouncer and quiesce/reset/release sequencer
//
// Purpose: accepts the asynchronous ip_sel pad value once it has been stable for
// STABLE_CYC synchronized cycles. It then asks the current IP to quiesce, holds
// the IP in reset across the select change, and re-enables the output clock gate.
//
// Ports:
//   sys_clk_i     in   system clock
//   rst_n         in   asynchronous active-low reset
//   ip_sel_pad_i  in   raw pad select value (asynchronous)
//   ip_idle_i     in   current IP is quiescent
//   ip_quiesce_o  out  request the current IP to stop activity
//   ip_rst_n_o    out  active-low reset to the IP block
//   ip_sel_o      out  accepted selection driving the IP mux
//   clk_out_en_o  out  gate enable for sys_clk_o_pad
//   sel_change_o  out  one-cycle pulse when ip_sel_o updates
//   timeout_o     out  sticky quiesce-wait timeout flag
//
// Build option: define IP_SEL_TIMEOUT_EN to bound the QUIESCE wait by QUIESCE_TIMEOUT cycles.

module ip_sel_ctrl #(
    parameter int SEL_W           = 3,
    parameter int STABLE_CYC      = 16,
    parameter int RST_HOLD        = 8,
    parameter int QUIESCE_TIMEOUT = 256
) (
    input  logic             sys_clk_i,
    input  logic             rst_n,
    input  logic [SEL_W-1:0] ip_sel_pad_i,
    input  logic             ip_idle_i,
    output logic             ip_quiesce_o,
    output logic             ip_rst_n_o,
    output logic [SEL_W-1:0] ip_sel_o,
    output logic             clk_out_en_o,
    output logic             sel_change_o,
    output logic             timeout_o
);

    localparam int CNT_W  = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;
    localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(STABLE_CYC - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(RST_HOLD - 1);

    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_RUN     = 3'd1,
        ST_QUIESCE = 3'd2,
        ST_SWITCH  = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    logic [SEL_W-1:0]  sync1_q, sync2_q, cand_q;
    logic [1:0]        sync_vld_q;
    logic              cand_vld_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              stable;

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  ip_sel_q, ip_sel_d;
    logic              sel_change_q, sel_change_d;
    logic              quiesce_q, quiesce_d;
    logic              ip_rst_n_q, ip_rst_n_d;
    logic              clk_en_q, clk_en_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

    // Synchronizer and debouncer. sync_vld_q marks when sync2 holds a real pad
    // sample after reset, so the first candidate is loaded at the same edge as
    // for any later pad change and power-up timing matches a normal switch.
    always_ff @(posedge sys_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            sync_vld_q <= '0;
            cand_q     <= '0;
            cand_vld_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            sync1_q    <= ip_sel_pad_i;
            sync2_q    <= sync1_q;
            sync_vld_q <= {sync_vld_q[0], 1'b1};
            if (sync_vld_q[1]) begin
                if (!cand_vld_q || (sync2_q != cand_q)) begin
                    cand_q     <= sync2_q;
                    cand_vld_q <= 1'b1;
                    cnt_q      <= '0;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign stable = cand_vld_q && (cnt_q == CNT_MAX);

`ifdef IP_SEL_TIMEOUT_EN
    localparam int TO_W = (QUIESCE_TIMEOUT > 1) ? $clog2(QUIESCE_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(QUIESCE_TIMEOUT - 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            timeout_q, timeout_d;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (QUIESCE_TIMEOUT > 0);
`endif

    always_comb begin
        state_d      = state_q;
        ip_sel_d     = ip_sel_q;
        sel_change_d = 1'b0;
        hold_cnt_d   = '0;
`ifdef IP_SEL_TIMEOUT_EN
        to_cnt_d     = '0;
        timeout_d    = timeout_q;
`endif
        case (state_q)
            ST_INIT: begin
                if (stable) begin
                    ip_sel_d     = cand_q;
                    sel_change_d = 1'b1;
                    state_d      = ST_RELEASE;
                end
            end
            ST_RUN: begin
                if (stable && (cand_q != ip_sel_q)) state_d = ST_QUIESCE;
            end
            ST_QUIESCE: begin
                if (ip_idle_i) begin
                    state_d = ST_SWITCH;
`ifdef IP_SEL_TIMEOUT_EN
                end else if (to_cnt_q == TO_MAX) begin
                    state_d   = ST_SWITCH;
                    timeout_d = 1'b1;
`endif
                end else if (stable && (cand_q == ip_sel_q)) begin
                    state_d = ST_RUN;
                end else begin
`ifdef IP_SEL_TIMEOUT_EN
                    to_cnt_d = to_cnt_q + 1'b1;
`endif
                end
            end
            ST_SWITCH: begin
                // IP stays in reset until the pad value settles again.
                if (stable) begin
                    ip_sel_d     = cand_q;
                    sel_change_d = 1'b1;
                    state_d      = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (hold_cnt_q == HOLD_MAX) state_d = ST_RUN;
                else                        hold_cnt_d = hold_cnt_q + 1'b1;
            end
            default: state_d = ST_INIT;
        endcase

        // Outputs decoded from the next state so they register with it.
        quiesce_d  = 1'b0;
        ip_rst_n_d = 1'b0;
        clk_en_d   = 1'b0;
        case (state_d)
            ST_RUN: begin
                ip_rst_n_d = 1'b1;
                clk_en_d   = 1'b1;
            end
            ST_QUIESCE: begin
                quiesce_d  = 1'b1;
                ip_rst_n_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_INIT;
            ip_sel_q     <= '0;
            sel_change_q <= 1'b0;
            quiesce_q    <= 1'b0;
            ip_rst_n_q   <= 1'b0;
            clk_en_q     <= 1'b0;
            hold_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            ip_sel_q     <= ip_sel_d;
            sel_change_q <= sel_change_d;
            quiesce_q    <= quiesce_d;
            ip_rst_n_q   <= ip_rst_n_d;
            clk_en_q     <= clk_en_d;
            hold_cnt_q   <= hold_cnt_d;
        end
    end

`ifdef IP_SEL_TIMEOUT_EN
    always_ff @(posedge sys_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            timeout_q <= timeout_d;
        end
    end
    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

    assign ip_quiesce_o = quiesce_q;
    assign ip_rst_n_o   = ip_rst_n_q;
    assign ip_sel_o     = ip_sel_q;
    assign clk_out_en_o = clk_en_q;
    assign sel_change_o = sel_change_q;

endmodule

// File: tb/tb_ip_sel_ctrl.sv
// tb/tb_ip_sel_ctrl.sv - directed self-checking bench for ip_sel_ctrl

module tb_ip_sel_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] pad = 3'b000;
    logic       idle = 1'b1;
    logic       quiesce, ip_rst_n, clk_en, sel_chg, tmo;
    logic [2:0] sel;

    int n_vec = 0;
    int n_bad = 0;
    int e_cnt = -1;

    always #20 clk = ~clk;

    ip_sel_ctrl dut (
        .sys_clk_i   (clk),
        .rst_n       (rst_n),
        .ip_sel_pad_i(pad),
        .ip_idle_i   (idle),
        .ip_quiesce_o(quiesce),
        .ip_rst_n_o  (ip_rst_n),
        .ip_sel_o    (sel),
        .clk_out_en_o(clk_en),
        .sel_change_o(sel_chg),
        .timeout_o   (tmo)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance until edge e (relative to the last stimulus) has passed, then settle 1 ns.
    task automatic run_to(input int e);
        while (e_cnt < e) begin
            @(posedge clk);
            e_cnt++;
        end
        #1;
    endtask

    // Apply a pad value just after a rising edge; the next edge becomes edge 0.
    task automatic set_pad(input logic [2:0] v);
        pad   = v;
        e_cnt = -1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_quiesce"}, quiesce, 0);
        check({tag, "_rst_n"}, ip_rst_n, 0);
        check({tag, "_sel"}, sel, 0);
        check({tag, "_clk_en"}, clk_en, 0);
        check({tag, "_sel_chg"}, sel_chg, 0);
        check({tag, "_timeout"}, tmo, 0);
    endtask

    logic seen_q, seen_sel, seen_chg, seen_rst;

    initial begin
        // Power-up reset
        #1000;
        check_reset_vals("por");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        e_cnt = -1;
        run_to(17);
        check("por_chg_e17", sel_chg, 0);
        run_to(18);
        check("por_chg_e18", sel_chg, 1);
        check("por_sel_e18", sel, 3'b000);
        run_to(25);
        check("por_rst_e25", ip_rst_n, 0);
        check("por_clken_e25", clk_en, 0);
        run_to(26);
        check("por_rst_e26", ip_rst_n, 1);
        check("por_clken_e26", clk_en, 1);

        // Glitch: pad0 high for 10 cycles
        seen_q = 0; seen_sel = 0; seen_chg = 0;
        set_pad(3'b001);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
        end
        #1;
        set_pad(3'b000);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (quiesce) seen_q = 1;
            if (sel != 3'b000) seen_sel = 1;
            if (sel_chg) seen_chg = 1;
        end
        check("glitch_quiesce", seen_q, 0);
        check("glitch_sel", seen_sel, 0);
        check("glitch_chg", seen_chg, 0);

        // Switch 000 -> 001 with ip_idle high
        @(posedge clk);
        #1;
        set_pad(3'b001);
        run_to(17);
        check("sw_quiesce_e17", quiesce, 0);
        run_to(18);
        check("sw_quiesce_e18", quiesce, 1);
        check("sw_clken_e18", clk_en, 0);
        run_to(19);
        check("sw_rst_e19", ip_rst_n, 0);
        check("sw_quiesce_e19", quiesce, 0);
        run_to(20);
        check("sw_sel_e20", sel, 3'b001);
        check("sw_chg_e20", sel_chg, 1);
        run_to(21);
        check("sw_chg_e21", sel_chg, 0);
        run_to(27);
        check("sw_clken_e27", clk_en, 0);
        check("sw_rst_e27", ip_rst_n, 0);
        run_to(28);
        check("sw_clken_e28", clk_en, 1);
        check("sw_rst_e28", ip_rst_n, 1);

        // Abort: pad reverts while waiting in QUIESCE
        idle = 1'b0;
        seen_rst = 0;
        set_pad(3'b000);
        fork
            begin
                for (int i = 0; i < 45; i++) begin
                    @(negedge clk);
                    if (!ip_rst_n) seen_rst = 1;
                end
            end
            begin
                run_to(18);
                check("ab_quiesce_e18", quiesce, 1);
                set_pad(3'b001);
                run_to(17);
                check("ab_quiesce_r17", quiesce, 1);
                run_to(18);
                check("ab_quiesce_r18", quiesce, 0);
                check("ab_clken_r18", clk_en, 1);
                check("ab_sel_r18", sel, 3'b001);
            end
        join
        check("ab_rst_never_low", seen_rst, 0);

        // Quiesce timeout (or indefinite wait without the timeout build)
        @(posedge clk);
        #1;
        set_pad(3'b010);
        run_to(18);
        check("to_quiesce_e18", quiesce, 1);
`ifdef IP_SEL_TIMEOUT_EN
        run_to(18 + 255);
        check("to_quiesce_pre", quiesce, 1);
        check("to_flag_pre", tmo, 0);
        run_to(18 + 256);
        check("to_rst_sw", ip_rst_n, 0);
        check("to_flag", tmo, 1);
        run_to(18 + 257);
        check("to_sel", sel, 3'b010);
        check("to_chg", sel_chg, 1);
`else
        run_to(18 + 2000);
        check("nto_quiesce", quiesce, 1);
        check("nto_flag", tmo, 0);
        check("nto_sel", sel, 3'b001);
        check("nto_rst", ip_rst_n, 1);
`endif
        idle = 1'b1;
        e_cnt = -1;
        run_to(12);
        check("to_final_sel", sel, 3'b010);
        check("to_final_clken", clk_en, 1);

        // Reset asserted during RELEASE
        set_pad(3'b011);
        run_to(22);
        check("mr_rst_in_release", ip_rst_n, 0);
        check("mr_sel_in_release", sel, 3'b011);
        #5;
        rst_n = 1'b0;
        #1;
        check_reset_vals("mr");
        @(posedge clk);
        @(posedge clk);
        #1;
        check_reset_vals("mr_hold");
        rst_n = 1'b1;
        e_cnt = -1;
        run_to(17);
        check("mr_sel_e17", sel, 3'b000);
        run_to(18);
        check("mr_sel_e18", sel, 3'b011);
        check("mr_chg_e18", sel_chg, 1);
        run_to(26);
        check("mr_rst_e26", ip_rst_n, 1);
        check("mr_clken_e26", clk_en, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
